// File: rtl/frame_stream_reader_pkg.sv
// Shared definitions for the pattern-recognition pixel stream.
// Holds the default frame geometry, the pixel-stream beat layout and the
// reader FSM state type. convolution_filter uses the same geometry constants.
package frame_stream_reader_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;
  localparam int unsigned PIX_W          = 8;

  // One pixel-stream beat: pixel value plus frame/line markers.
  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  // Counter width for n distinct values; never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry registered FIFO for pixel beats.
// The head entry is a register so it can drive the stream outputs directly.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   push_i / din_i   write a beat (ignored when full and not popping)
//   pop_i            remove the head beat (ignored when empty)
//   head_o           current head beat
//   empty_o, full_o  occupancy flags
//   count_o          occupancy, 0..2
module pixel_skid_fifo
  import frame_stream_reader_pkg::*;
#(
  parameter type beat_t = pix_beat_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  beat_t      din_i,
  input  logic       pop_i,
  output beat_t      head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic [1:0] count_o
);

  logic [1:0] cnt_q, cnt_d;
  beat_t      head_q, head_d;
  beat_t      tail_q, tail_d;
  logic       pop, push;

  always_comb begin
    pop    = pop_i && (cnt_q != 2'd0);
    push   = push_i && ((cnt_q != 2'd2) || pop);
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = din_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        unique case ({push, pop})
          2'b10: begin
            tail_d = din_i;
            cnt_d  = 2'd2;
          end
          2'b01: cnt_d  = 2'd0;
          2'b11: head_d = din_i;
          default: ;
        endcase
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = din_i;
          else      cnt_d  = 2'd1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_o  = head_q;
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign count_o = cnt_q;

endmodule

// File: rtl/frame_stream_reader.sv
// Streams one stored frame from a synchronous-read memory as a raster-order
// valid/ready pixel stream with sof/eol/eof markers.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 request one frame (sampled while busy=0)
//   busy, done            frame in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr   memory read strobe and pixel index
//   mem_rd_data           read data, one cycle after mem_rd_en
//   m_valid, m_ready      output handshake
//   m_data, m_sof/eol/eof output pixel and markers
module frame_stream_reader
  import frame_stream_reader_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned W          = PIX_W,
  parameter int unsigned ADDR_W     = width_of(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W-1:0]      m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int unsigned CW = width_of(IMG_WIDTH);
  localparam int unsigned RW = width_of(IMG_HEIGHT);

  typedef struct packed {
    logic [W-1:0] data;
    logic         sof;
    logic         eol;
    logic         eof;
  } beat_t;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              in_flight_q;
  logic [2:0]        tag_q;
  logic              done_q;

  beat_t      head, push_beat;
  logic       fifo_empty, fifo_full;
  logic [1:0] occ;
  logic       pop, issue, at_first, at_eol, at_last, eof_pop;

  assign m_valid  = !fifo_empty;
  assign pop      = m_valid && m_ready;
  assign at_first = (addr_q == '0);
  assign at_eol   = (col_q == CW'(IMG_WIDTH - 1));
  assign at_last  = at_eol && (row_q == RW'(IMG_HEIGHT - 1));
  assign eof_pop  = (state_q == ST_DRAIN) && pop && head.eof;

  // occupancy + in_flight - pop < 2, rearranged to avoid underflow.
  assign issue = (state_q == ST_RUN) &&
                 (({1'b0, occ} + {2'b0, in_flight_q}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          // Address holds on the last pixel so it never leaves the frame.
          if (at_last) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (at_eol) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (eof_pop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      in_flight_q <= 1'b0;
      tag_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      in_flight_q <= issue;
      if (issue) tag_q <= {at_first, at_eol, at_last};
      done_q      <= eof_pop;
    end
  end

  // Markers travel alongside the read so they line up with the returned data.
  always_comb begin
    push_beat.data = mem_rd_data;
    push_beat.sof  = tag_q[2];
    push_beat.eol  = tag_q[1];
    push_beat.eof  = tag_q[0];
  end

  pixel_skid_fifo #(
    .beat_t(beat_t)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (in_flight_q),
    .din_i  (push_beat),
    .pop_i  (pop),
    .head_o (head),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .count_o(occ)
  );

  // The issue rule must keep a returning read from finding the buffer full.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(fifo_full && in_flight_q && !pop));

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign m_data    = head.data;
  assign m_sof     = head.sof;
  assign m_eol     = head.eol;
  assign m_eof     = head.eof;

endmodule

// File: tb/tb_frame_stream_reader.sv
module tb_frame_stream_reader;

  localparam int unsigned WID = 4;
  localparam int unsigned HGT = 3;
  localparam int unsigned N   = WID * HGT;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          m_valid, m_ready, m_sof, m_eol, m_eof;
  logic [7:0]    m_data;

  always #5 clk = ~clk;

  frame_stream_reader #(
    .IMG_WIDTH (WID),
    .IMG_HEIGHT(HGT),
    .W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof)
  );

  // Frame memory with one-cycle read latency.
  logic [7:0] mem [N];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  typedef struct {
    logic [7:0]  data;
    logic        sof, eol, eof;
    int unsigned idx;
  } exp_t;

  exp_t        q[$];
  int          nchk = 0;
  int          nfail = 0;
  int unsigned cyc = 0;
  int unsigned fstart = 0;
  int unsigned beats = 0;
  int unsigned exp_addr = 0;
  bit          timed = 0;
  bit          ready_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: held high or a fair coin each cycle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability, done pulse, read addresses.
  bit         prev_stall = 0;
  bit         eof_prev = 0;
  logic [10:0] prev_bits = '0;
  always @(negedge clk) begin
    exp_t e;
    bit   hs;
    if (!rst_n) begin
      prev_stall = 0;
      eof_prev   = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_beat_held", {m_data, m_sof, m_eol, m_eof}, prev_bits);
      end
      if (done || eof_prev) check("done_after_eof", done, eof_prev);
      if (mem_rd_en) begin
        check("rd_addr_seq", mem_addr, exp_addr);
        check("rd_addr_range", mem_addr < AW'(N), 1);
        exp_addr++;
      end
      hs = m_valid && m_ready;
      if (hs) begin
        if (q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_beat: got data %0h expected no beat (t=%0t)", m_data, $time);
        end else begin
          e = q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_markers", {m_sof, m_eol, m_eof}, {e.sof, e.eol, e.eof});
          if (timed) check("beat_cycle", cyc - fstart, 2 + e.idx);
          beats++;
        end
      end
      eof_prev   = hs && m_eof;
      prev_stall = m_valid && !m_ready;
      prev_bits  = {m_data, m_sof, m_eol, m_eof};
    end
  end

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < int'(N); i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  // Reference frame: raster order, markers from index arithmetic.
  task automatic push_frame();
    for (int unsigned i = 0; i < N; i++) begin
      exp_t e;
      e.data = mem[i];
      e.sof  = (i == 0);
      e.eol  = ((i % WID) == WID - 1);
      e.eof  = (i == N - 1);
      e.idx  = i;
      q.push_back(e);
    end
  endtask

  // Caller has start=1 with the DUT idle; the next edge accepts it.
  task automatic accept_start();
    @(posedge clk);
    #1;
    start    = 1'b0;
    fstart   = cyc;
    beats    = 0;
    exp_addr = 0;
    push_frame();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("first_read", {mem_rd_en, mem_addr}, {1'b1, AW'(0)});
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    accept_start();
  endtask

  task automatic wait_done(input int unsigned budget);
    bit seen = 0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    check("frame_beats", beats, N);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, mem_rd_en, m_valid, m_sof, m_eol, m_eof}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", m_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame with continuous ready: exact cycle timing.
    fill_mem(0);
    ready_rand = 0;
    timed      = 1;
    start_frame();
    wait_done(60);

    // Random backpressure, start pulses while busy must be ignored.
    repeat (2) @(negedge clk);
    ready_rand = 1;
    timed      = 0;
    start_frame();
    repeat (3) @(negedge clk);
    start = 1'b1;
    check("busy_at_ignored_start1", busy, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    check("busy_at_ignored_start2", busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(300);

    // Start in the done cycle: next frame follows with no gap.
    fill_mem(1);
    ready_rand = 0;
    timed      = 1;
    start      = 1'b1;
    accept_start();
    wait_done(60);

    // Reset abort after beat 5.
    fill_mem(1);
    start_frame();
    begin
      bit reached = 0;
      for (int i = 0; i < 60 && !reached; i++) begin
        @(negedge clk);
        #1;
        if (beats >= 6) reached = 1;
      end
      check("abort_point_reached", reached, 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ctrl", {busy, done, mem_rd_en, m_valid, m_sof, m_eol, m_eof}, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_data", m_data, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_after_abort", {m_valid, mem_rd_en, busy}, 0);
    end

    // Clean frame after abort, random data and backpressure.
    fill_mem(1);
    ready_rand = 1;
    timed      = 0;
    start_frame();
    wait_done(300);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/frame_stream_reader.md
# frame_stream_reader

Streams one stored grayscale frame from a synchronous-read frame memory as a raster-order pixel stream with valid/ready handshake. It is the source side of the pattern-recognition pixel interface: its master port drives the `x_valid`/`x_ready`/`x_data` input of `convolution_filter` directly. It hides the one-cycle memory read latency behind a two-entry output buffer, so it sustains one pixel per cycle under continuous `m_ready` and loses nothing under arbitrary backpressure.

## Interface
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- W, 8, pixel width in bits
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT) (19), memory address width
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request one frame; sampled only while busy=0
- busy  out  1  high from the cycle after start is accepted until the last pixel handshake
- done  out  1  one-cycle pulse, the cycle after the last pixel handshake
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address, pixel index = row*IMG_WIDTH + col
- mem_rd_data  in  W  read data, valid exactly 1 cycle after the mem_rd_en cycle
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  W  pixel value
- m_sof  out  1  marks pixel 0
- m_eol  out  1  marks col = IMG_WIDTH-1
- m_eof  out  1  marks the last pixel, index IMG_WIDTH*IMG_HEIGHT-1

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start=1. This clears the read address counter and the row/col counters.
- RUN issues reads. Each read is tagged with sof/eol/eof, derived from col/row counters. col wraps at IMG_WIDTH-1 and increments row.
- RUN -> DRAIN in the cycle the read for the last pixel issues. No reads issue in DRAIN.
- DRAIN -> IDLE on the handshake of the eof pixel. done pulses the next cycle.
- Output buffer: 2-entry FIFO of {data, sof, eol, eof}. The head is registered and drives the m_* outputs.
- Read issue rule: occupancy + in_flight − (m_valid & m_ready) < 2. in_flight is 0 or 1.
- Handshake: a pixel transfers when m_valid & m_ready at a rising edge.
- While m_valid=1 and m_ready=0, m_data and the marker bits hold stable. m_valid never drops without a transfer.
- start while busy=1 is ignored.
- start in the done cycle is accepted, since busy=0 in that cycle. The next frame then begins with no extra idle cycle.
- IMG_WIDTH*IMG_HEIGHT = 1 is legal. The single pixel carries sof, eol and eof together.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0. Buffer, in_flight and counters are cleared.
- rst_n low mid-frame aborts the frame. Outputs take their reset values at the next edge, and data arriving on mem_rd_data afterwards is discarded.
- Latency, with start sampled at edge 0:
  - busy=1 and the first mem_rd_en (addr 0) during cycle 1.
  - Data on mem_rd_data in cycle 2.
  - m_valid=1 with pixel 0 from cycle 3.
- Throughput with m_ready held high: one pixel per cycle, with no bubbles across line boundaries.
- A frame of N pixels with m_ready=1 gives its last transfer at edge N+2 and done during cycle N+3.
- mem_addr advances by one only on an issued read. It is never re-read and never skipped.

## Structure
- Shared package (pattern-recognition package), holding:
  - the pixel-stream beat typedef struct {logic [W-1:0] data; logic sof, eol, eof;}
  - the reader FSM state enum
  - the default IMG_WIDTH/IMG_HEIGHT constants, also used by convolution_filter.
- One sub-module, `pixel_skid_fifo`: a 2-entry registered FIFO with push/pop, full/empty and occupancy. The top level holds the FSM, counters and issue logic.

## Test plan
- Single frame, IMG_WIDTH=4, IMG_HEIGHT=3, memory[i]=i, m_ready=1 -> m_data 0..11 on 12 consecutive cycles. The first beat is 3 cycles after start, and done pulses once the cycle after beat 11.
- Same frame with m_ready pseudo-random, 50% duty -> exact sequence 0..11 with no drop or duplicate. m_data and markers are stable across every stall, and mem_addr never exceeds 11.
- Markers -> m_sof only on beat 0; m_eol on beats 3, 7, 11; m_eof only on beat 11.
- start pulsed at cycles 5 and 8 during a frame -> ignored, and exactly 12 beats result. start asserted in the done cycle -> second frame 0..11 begins with no gap.
- rst_n low for 1 cycle after beat 5 -> all outputs return to reset values, no further beats appear, and a following start yields a clean full frame from pixel 0.
- Full 640x480 frame from image_grayscale.mif feeding convolution_filter -> 307200 transfers and one done pulse. The filter output count is 307200.
